// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID->EX ALU-control issue stage: MIPS opcode/funct
// fields, the 6-bit ALU operation codes and the issue FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;
    localparam logic [5:0] FN_ABS  = 6'h3F;

    localparam logic [5:0] ALU_ADD     = 6'd0;
    localparam logic [5:0] ALU_ADDU    = 6'd2;
    localparam logic [5:0] ALU_ADDI    = 6'd3;
    localparam logic [5:0] ALU_SUB     = 6'd4;
    localparam logic [5:0] ALU_MUL     = 6'd5;
    localparam logic [5:0] ALU_LW      = 6'd10;
    localparam logic [5:0] ALU_SW      = 6'd11;
    localparam logic [5:0] ALU_BEQ     = 6'd18;
    localparam logic [5:0] ALU_BNE     = 6'd19;
    localparam logic [5:0] ALU_J       = 6'd23;
    localparam logic [5:0] ALU_JR      = 6'd24;
    localparam logic [5:0] ALU_JAL     = 6'd25;
    localparam logic [5:0] ALU_ANDI    = 6'd27;
    localparam logic [5:0] ALU_ORI     = 6'd31;
    localparam logic [5:0] ALU_SLL     = 6'd34;
    localparam logic [5:0] ALU_SRL     = 6'd35;
    localparam logic [5:0] ALU_SLT     = 6'd38;
    localparam logic [5:0] ALU_SLTI    = 6'd39;
    localparam logic [5:0] ALU_ABS     = 6'd40;
    localparam logic [5:0] ALU_DIV     = 6'd51;
    localparam logic [5:0] ALU_ILLEGAL = 6'd63;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_e;

    // Only the two immediate shifts forward the shamt field to the ALU.
    function automatic logic takes_shamt(input logic [5:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_ctrl_issue_decode.sv
// Combinational MIPS instruction -> ALU control decoder; anything outside the
// supported table decodes to the illegal code.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [5:0]  code,
    output logic [4:0]  sa,
    output logic        illegal,
    output logic        is_mul,
    output logic        is_div
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic       unused_fields_s;

    assign op_s            = instruction[31:26];
    assign funct_s         = instruction[5:0];
    assign unused_fields_s = &{1'b0, instruction[25:11]};

    // Opcode/funct lookup; the all-zero nop falls out as sll with shamt 0.
    always_comb begin
        code = ALU_ILLEGAL;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD:  code = ALU_ADD;
                    FN_ADDU: code = ALU_ADDU;
                    FN_SUB:  code = ALU_SUB;
                    FN_SLT:  code = ALU_SLT;
                    FN_DIV:  code = ALU_DIV;
                    FN_SLL:  code = ALU_SLL;
                    FN_SRL:  code = ALU_SRL;
                    FN_JR:   code = ALU_JR;
                    default: code = ALU_ILLEGAL;
                endcase
            end
            OP_SPECIAL2: begin
                case (funct_s)
                    FN_MUL:  code = ALU_MUL;
                    FN_ABS:  code = ALU_ABS;
                    default: code = ALU_ILLEGAL;
                endcase
            end
            OP_ADDI: code = ALU_ADDI;
            OP_LW:   code = ALU_LW;
            OP_SW:   code = ALU_SW;
            OP_BEQ:  code = ALU_BEQ;
            OP_BNE:  code = ALU_BNE;
            OP_J:    code = ALU_J;
            OP_JAL:  code = ALU_JAL;
            OP_ANDI: code = ALU_ANDI;
            OP_ORI:  code = ALU_ORI;
            OP_SLTI: code = ALU_SLTI;
            default: code = ALU_ILLEGAL;
        endcase
    end

    // Shamt is only meaningful for sll/srl; zero it otherwise.
    always_comb begin
        if (takes_shamt(code)) begin
            sa = instruction[10:6];
        end else begin
            sa = 5'd0;
        end
    end

    assign illegal = (code == ALU_ILLEGAL);
    assign is_mul  = (code == ALU_MUL);
    assign is_div  = (code == ALU_DIV);

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage: decodes the instruction, registers the ALU control
// fields behind valid/ready and holds mul/div for their fixed latency.
module alu_ctrl_issue
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  alu_control,
    output logic [4:0]  sa,
    output logic        illegal,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    issue_state_e     state_r;
    issue_state_e     state_next_s;
    issue_state_e     eff_state_s;
    issue_state_e     load_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_load_s;
    logic [5:0]       dec_code_s;
    logic [4:0]       dec_sa_s;
    logic             dec_illegal_s;
    logic             dec_is_mul_s;
    logic             dec_is_div_s;
    logic             accept_s;

    alu_ctrl_decode u_decode (
        .instruction (instruction),
        .code        (dec_code_s),
        .sa          (dec_sa_s),
        .illegal     (dec_illegal_s),
        .is_mul      (dec_is_mul_s),
        .is_div      (dec_is_div_s)
    );

    assign accept_s = in_valid & in_ready;

    // A WAIT whose count has run out behaves exactly like HOLD.
    always_comb begin
        if ((state_r == ST_WAIT) && (cnt_r == CNT_ZERO)) begin
            eff_state_s = ST_HOLD;
        end else begin
            eff_state_s = state_r;
        end
    end

    // Where a freshly accepted op lands; a latency of 1 skips WAIT entirely.
    always_comb begin
        if (dec_is_mul_s) begin
            cnt_load_s   = MUL_LOAD;
            load_state_s = (MUL_LAT > 1) ? ST_WAIT : ST_HOLD;
        end else if (dec_is_div_s) begin
            cnt_load_s   = DIV_LOAD;
            load_state_s = (DIV_LAT > 1) ? ST_WAIT : ST_HOLD;
        end else begin
            cnt_load_s   = CNT_ZERO;
            load_state_s = ST_HOLD;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush empties the slot regardless of state.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (eff_state_s)
                ST_EMPTY: state_next_s = accept_s ? load_state_s : ST_EMPTY;
                ST_WAIT:  state_next_s = (cnt_r == CNT_ONE) ? ST_HOLD : ST_WAIT;
                ST_HOLD: begin
                    if (out_ready) begin
                        state_next_s = accept_s ? load_state_s : ST_EMPTY;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default:  state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Handshake/status outputs decoded from the effective state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (eff_state_s)
            ST_EMPTY: in_ready = ~rst & ~flush;
            ST_WAIT:  busy = 1'b1;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = ~rst & ~flush & out_ready;
            end
            default:  in_ready = 1'b0;
        endcase
    end

    // Latency counter: loaded on accept, counts down only while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (flush) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            cnt_r <= cnt_load_s;
        end else if (eff_state_s == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output payload registers, captured on the accept edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control <= 6'd0;
            sa          <= 5'd0;
            illegal     <= 1'b0;
        end else if (accept_s) begin
            alu_control <= dec_code_s;
            sa          <= dec_sa_s;
            illegal     <= dec_illegal_s;
        end else begin
            alu_control <= alu_control;
            sa          <= sa;
            illegal     <= illegal;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Randomized scoreboard bench for alu_ctrl_issue; a table-driven reference
// model predicts the payload and the cycle each accepted op becomes visible.
module tb_alu_ctrl_issue;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int NLEG    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  alu_control;
    logic [4:0]  sa;
    logic        illegal;
    logic        busy;

    typedef struct {
        int code;
        int sa;
        int ill;
        int lat;
        int acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rtab[int];
    int          itab[int];
    int          stab[int];
    logic [31:0] tmpl[NLEG];

    alu_ctrl_issue #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .sa          (sa),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input int now);
        exp_t e;
        int   op;
        int   fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0 && rtab.exists(fn))          e.code = rtab[fn];
        else if (op == 28 && stab.exists(fn))    e.code = stab[fn];
        else if (op != 0 && op != 28 && itab.exists(op)) e.code = itab[op];
        else                                     e.code = 63;
        e.ill = (e.code == 63) ? 1 : 0;
        e.sa  = (e.code == 34 || e.code == 35) ? int'(ins[10:6]) : 0;
        e.lat = (e.code == 5) ? MUL_LAT : ((e.code == 51) ? DIV_LAT : 1);
        e.acc = now;
        return e;
    endfunction

    // Monitor/scoreboard: one pass per cycle at the falling edge.
    initial begin
        bit   pres;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("in_ready_in_reset", int'(in_ready), 0);
                chk("out_valid_in_reset", int'(out_valid), 0);
                sb.delete();
            end else begin
                pres = (sb.size() > 0) && (cyc - sb[0].acc >= sb[0].lat);
                chk("out_valid", int'(out_valid), int'(pres));
                chk("busy", int'(busy), int'((sb.size() > 0) && !pres));
                chk("in_ready", int'(in_ready),
                    int'(!flush && ((sb.size() == 0) || (pres && out_ready))));
                if (pres && out_valid) begin
                    chk("alu_control", int'(alu_control), sb[0].code);
                    chk("sa", int'(sa), sb[0].sa);
                    chk("illegal", int'(illegal), sb[0].ill);
                end
                if (pres && out_ready) void'(sb.pop_front());
                if (flush) sb.delete();
                if (in_valid && !flush && ((sb.size() == 0) || (pres && out_ready))) begin
                    e = ref_decode(instruction, cyc);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; flush = 1'b0; out_ready = ordy;
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic ordy);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; instruction = ins; out_ready = ordy; flush = 1'b0;
        @(negedge clk);
        while (!in_ready) begin
            if (n >= 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        if ($urandom_range(0, 5) == 0) return r;
        if ($urandom_range(0, 15) == 0) return 32'd0;
        k = $urandom_range(0, NLEG - 1);
        if (k < 10) return (r & 32'h03FF_FFC0) | tmpl[k];
        return (r & 32'h03FF_FFFF) | tmpl[k];
    endfunction

    initial begin
        rtab[32] = 0;  rtab[33] = 2;  rtab[34] = 4;  rtab[42] = 38;
        rtab[26] = 51; rtab[0] = 34;  rtab[2] = 35;  rtab[8] = 24;
        itab[8] = 3;   itab[35] = 10; itab[43] = 11; itab[4] = 18;  itab[5] = 19;
        itab[2] = 23;  itab[3] = 25;  itab[12] = 27; itab[13] = 31; itab[10] = 39;
        stab[2] = 5;   stab[63] = 40;
        tmpl = '{32'h0000_0020, 32'h0000_0021, 32'h0000_0022, 32'h0000_002A,
                 32'h0000_001A, 32'h0000_0000, 32'h0000_0002, 32'h0000_0008,
                 32'h7000_0002, 32'h7000_003F,
                 32'h2000_0000, 32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000,
                 32'h1400_0000, 32'h0800_0000, 32'h0C00_0000, 32'h3000_0000,
                 32'h3400_0000, 32'h2800_0000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_alu_control", int'(alu_control), 0);
        chk("reset_sa", int'(sa), 0);
        chk("reset_illegal", int'(illegal), 0);
        chk("ready_after_reset", int'(in_ready), 1);

        send(32'h0022_1820, 1'b1);                       // add
        idle(2, 1'b1);
        send(32'h8C22_0004, 1'b1);                       // lw, sw, beq back to back
        send(32'hAC22_0004, 1'b1);
        send(32'h1022_0004, 1'b1);
        idle(2, 1'b1);
        send(32'h0022_001A, 1'b1);                       // div
        idle(DIV_LAT + 4, 1'b1);
        send(32'hFC00_0000, 1'b1);                       // illegal
        send(32'h0001_1100, 1'b1);                       // sll $2,$1,4
        idle(2, 1'b1);

        send(32'h7022_1002, 1'b1);                       // mul, flushed in 2nd WAIT cycle
        idle(1, 1'b1);
        @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1; instruction = 32'h0022_1820;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        idle(MUL_LAT + 2, 1'b1);

        send(32'h0022_1820, 1'b0);                       // backpressure then release
        idle(4, 1'b0);
        send(32'h0022_1822, 1'b1);
        send(32'h0022_1821, 1'b1);                       // flush with transfer in HOLD
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        idle(2, 1'b1);

        send(32'h0022_001A, 1'b1);                       // reset mid-WAIT
        idle(5, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(DIV_LAT + 4, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            in_valid    = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 40) == 0);
        end
        idle(DIV_LAT + 4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
